// File: rtl/prog_loader_if.sv
// Loader bus: byte stream in (valid/ready), imem/dmem write ports and status out.
// The master side is the byte source / observer; the slave side is the loader.
interface prog_loader_if #(
  parameter int IADDR_W = 8,
  parameter int DADDR_W = 5
);
  // Handshake: a byte moves on a rising clock edge where rx_valid_i && rx_ready_o;
  // the source holds rx_data_i stable while rx_valid_i is high and not yet accepted.
  logic [7:0]         rx_data_i;
  logic               rx_valid_i;
  logic               rx_ready_o;
  logic               imem_we_o;
  logic [IADDR_W-1:0] imem_addr_o;
  logic [31:0]        imem_data_o;
  logic               dmem_we_o;
  logic [DADDR_W-1:0] dmem_addr_o;
  logic [7:0]         dmem_data_o;
  logic               start_o;
  logic               busy_o;
  logic               err_o;

  modport master (
    output rx_data_i, rx_valid_i,
    input  rx_ready_o, imem_we_o, imem_addr_o, imem_data_o,
    input  dmem_we_o, dmem_addr_o, dmem_data_o, start_o, busy_o, err_o
  );

  modport slave (
    input  rx_data_i, rx_valid_i,
    output rx_ready_o, imem_we_o, imem_addr_o, imem_data_o,
    output dmem_we_o, dmem_addr_o, dmem_data_o, start_o, busy_o, err_o
  );
endinterface

// File: rtl/prog_loader.sv
// Boot-time program loader: parses I/D/G frames from a byte stream into imem/dmem writes
// and then starts the CPU. Define PROG_LOADER_CHECKSUM_EN for a trailing XOR byte per frame.
module prog_loader #(
  parameter int IMEM_WORDS = 256,
  parameter int DMEM_BYTES = 32,
  parameter int IADDR_W    = 8,
  parameter int DADDR_W    = 5
) (
  input  logic        clk_i,
  input  logic        rst_i,
  prog_loader_if.slave bus,
  output logic [2:0]  dbg_state_o
);

  localparam logic [7:0]  HDR_I = 8'h49;
  localparam logic [7:0]  HDR_D = 8'h44;
  localparam logic [7:0]  HDR_G = 8'h47;
  localparam logic [16:0] I_MAX = 17'(IMEM_WORDS);
  localparam logic [16:0] D_MAX = 17'(DMEM_BYTES);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CNT_LO = 3'd1,
    S_CNT_HI = 3'd2,
    S_IPAY   = 3'd3,
    S_DPAY   = 3'd4,
`ifdef PROG_LOADER_CHECKSUM_EN
    S_CHK    = 3'd5,
`endif
    S_RUN    = 3'd6,
    S_ERR    = 3'd7
  } state_t;

  // Where a frame goes once its payload (or an empty count) is done.
`ifdef PROG_LOADER_CHECKSUM_EN
  localparam state_t S_AFTER    = S_CHK;
  localparam logic   AFTER_BUSY = 1'b1;
`else
  localparam state_t S_AFTER    = S_IDLE;
  localparam logic   AFTER_BUSY = 1'b0;
`endif

  state_t             state;
  logic               is_i;
  logic [7:0]         cnt_lo;
  logic [15:0]        rem;
  logic [1:0]         lane;
  logic [23:0]        wbuf;
  logic [IADDR_W-1:0] widx;
  logic [DADDR_W-1:0] bidx;
`ifdef PROG_LOADER_CHECKSUM_EN
  logic [7:0]         csum;
`endif

  logic        accept;
  logic [15:0] cnt;
  logic        cnt_bad;

  always_comb begin
    accept  = bus.rx_valid_i && bus.rx_ready_o;
    cnt     = {bus.rx_data_i, cnt_lo};
    cnt_bad = is_i ? ({1'b0, cnt} > I_MAX) : ({1'b0, cnt} > D_MAX);
  end

  assign dbg_state_o = state;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state           <= S_IDLE;
      bus.rx_ready_o  <= 1'b0;
      bus.imem_we_o   <= 1'b0;
      bus.imem_addr_o <= '0;
      bus.imem_data_o <= '0;
      bus.dmem_we_o   <= 1'b0;
      bus.dmem_addr_o <= '0;
      bus.dmem_data_o <= '0;
      bus.start_o     <= 1'b0;
      bus.busy_o      <= 1'b0;
      bus.err_o       <= 1'b0;
      is_i            <= 1'b0;
      cnt_lo          <= '0;
      rem             <= '0;
      lane            <= '0;
      wbuf            <= '0;
      widx            <= '0;
      bidx            <= '0;
`ifdef PROG_LOADER_CHECKSUM_EN
      csum            <= '0;
`endif
    end else begin
      bus.imem_we_o <= 1'b0;
      bus.dmem_we_o <= 1'b0;
      if (state != S_RUN && state != S_ERR) bus.rx_ready_o <= 1'b1;
`ifdef PROG_LOADER_CHECKSUM_EN
      if (accept) csum <= (state == S_IDLE) ? bus.rx_data_i : (csum ^ bus.rx_data_i);
`endif
      if (accept) begin
        case (state)
          S_IDLE: begin
            if (bus.rx_data_i == HDR_I || bus.rx_data_i == HDR_D) begin
              is_i       <= (bus.rx_data_i == HDR_I);
              state      <= S_CNT_LO;
              bus.busy_o <= 1'b1;
            end else if (bus.rx_data_i == HDR_G) begin
              state          <= S_RUN;
              bus.start_o    <= 1'b1;
              bus.rx_ready_o <= 1'b0;
            end else begin
              state          <= S_ERR;
              bus.err_o      <= 1'b1;
              bus.rx_ready_o <= 1'b0;
            end
          end
          S_CNT_LO: begin
            cnt_lo <= bus.rx_data_i;
            state  <= S_CNT_HI;
          end
          S_CNT_HI: begin
            if (cnt == 16'd0) begin
              state      <= S_AFTER;
              bus.busy_o <= AFTER_BUSY;
            end else if (cnt_bad) begin
              state          <= S_ERR;
              bus.err_o      <= 1'b1;
              bus.rx_ready_o <= 1'b0;
              bus.busy_o     <= 1'b0;
            end else begin
              rem   <= cnt;
              lane  <= '0;
              widx  <= '0;
              bidx  <= '0;
              state <= is_i ? S_IPAY : S_DPAY;
            end
          end
          S_IPAY: begin
            // Lanes 0..2 shift into wbuf so the 4th byte lands on top as the MSB.
            lane <= lane + 2'd1;
            if (lane == 2'd3) begin
              bus.imem_we_o   <= 1'b1;
              bus.imem_addr_o <= widx;
              bus.imem_data_o <= {bus.rx_data_i, wbuf};
              widx            <= widx + 1'b1;
              rem             <= rem - 16'd1;
              if (rem == 16'd1) begin
                state      <= S_AFTER;
                bus.busy_o <= AFTER_BUSY;
              end
            end else begin
              wbuf <= {bus.rx_data_i, wbuf[23:8]};
            end
          end
          S_DPAY: begin
            bus.dmem_we_o   <= 1'b1;
            bus.dmem_addr_o <= bidx;
            bus.dmem_data_o <= bus.rx_data_i;
            bidx            <= bidx + 1'b1;
            rem             <= rem - 16'd1;
            if (rem == 16'd1) begin
              state      <= S_AFTER;
              bus.busy_o <= AFTER_BUSY;
            end
          end
`ifdef PROG_LOADER_CHECKSUM_EN
          S_CHK: begin
            bus.busy_o <= 1'b0;
            if (bus.rx_data_i == csum) begin
              state <= S_IDLE;
            end else begin
              state          <= S_ERR;
              bus.err_o      <= 1'b1;
              bus.rx_ready_o <= 1'b0;
            end
          end
`endif
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: randomized frame streams checked against a
// frame-level model of expected memory writes, write timing and final status.
module tb_prog_loader;
  localparam int IMEM_WORDS = 256;
  localparam int DMEM_BYTES = 32;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] dbg_state;

  always #5 clk = ~clk;

  prog_loader_if #(.IADDR_W(8), .DADDR_W(5)) bus ();

  prog_loader #(
    .IMEM_WORDS(IMEM_WORDS), .DMEM_BYTES(DMEM_BYTES), .IADDR_W(8), .DADDR_W(5)
  ) dut (
    .clk_i(clk), .rst_i(rst), .bus(bus), .dbg_state_o(dbg_state)
  );

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int start_cyc = -1;
  int err_cyc = -1;
  bit both_we = 1'b0;

  logic [39:0] act_i_q[$];
  logic [39:0] exp_i_q[$];
  int          act_i_cyc[$];
  int          exp_i_trig[$];
  logic [12:0] act_d_q[$];
  logic [12:0] exp_d_q[$];
  int          act_d_cyc[$];
  int          exp_d_trig[$];
  int          acc_cyc_q[$];
  logic [7:0]  stim_q[$];
  bit          exp_start, exp_err, exp_busy;

  // Monitor sampling on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (bus.rx_valid_i && bus.rx_ready_o) acc_cyc_q.push_back(cyc);
    if (bus.imem_we_o === 1'b1) begin
      act_i_q.push_back({bus.imem_addr_o, bus.imem_data_o});
      act_i_cyc.push_back(cyc);
    end
    if (bus.dmem_we_o === 1'b1) begin
      act_d_q.push_back({bus.dmem_addr_o, bus.dmem_data_o});
      act_d_cyc.push_back(cyc);
    end
    if (bus.imem_we_o === 1'b1 && bus.dmem_we_o === 1'b1) both_we = 1'b1;
    if (bus.start_o === 1'b1 && start_cyc < 0) start_cyc = cyc;
    if (bus.err_o === 1'b1 && err_cyc < 0) err_cyc = cyc;
    cyc++;
  end

  task automatic clear_sb();
    act_i_q.delete(); act_i_cyc.delete(); act_d_q.delete(); act_d_cyc.delete();
    acc_cyc_q.delete();
    start_cyc = -1;
    err_cyc   = -1;
    both_we   = 1'b0;
  endtask

  // ---------------- driver tasks ----------------
  task automatic reset_dut();
    bus.rx_valid_i = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic add_frame(input logic [7:0] hdr, input logic [15:0] cnt, input logic [7:0] pay[$]);
`ifdef PROG_LOADER_CHECKSUM_EN
    logic [7:0] x;
    x = hdr ^ cnt[7:0] ^ cnt[15:8];
    foreach (pay[i]) x ^= pay[i];
`endif
    stim_q.push_back(hdr);
    stim_q.push_back(cnt[7:0]);
    stim_q.push_back(cnt[15:8]);
    foreach (pay[i]) stim_q.push_back(pay[i]);
`ifdef PROG_LOADER_CHECKSUM_EN
    stim_q.push_back(x);
`endif
  endtask

  task automatic rand_pay(input int n, output logic [7:0] pay[$]);
    pay.delete();
    for (int i = 0; i < n; i++) pay.push_back(8'($urandom_range(0, 255)));
  endtask

  // Presents every byte of stim_q for one cycle each; bytes offered while the
  // loader refuses them are simply dropped.
  task automatic run_stream(input bit gaps);
    clear_sb();
    for (int i = 0; i < stim_q.size(); i++) begin
      if (gaps) begin
        bus.rx_valid_i = 1'b0;
        repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      end
      bus.rx_data_i  = stim_q[i];
      bus.rx_valid_i = 1'b1;
      @(posedge clk); #1;
    end
    bus.rx_valid_i = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
  endtask

  // ---------------- reference model ----------------
  // Walks stim_q frame by frame and lists the writes each frame must produce,
  // tagged with the stream index of the byte that completes them.
  task automatic model_stream();
    int         p, n, nb, pay;
    logic [15:0] c;
    logic [7:0] h;
    bit         halt, is_i;
`ifdef PROG_LOADER_CHECKSUM_EN
    logic [7:0] x;
`endif
    exp_i_q.delete(); exp_i_trig.delete(); exp_d_q.delete(); exp_d_trig.delete();
    exp_start = 0; exp_err = 0; exp_busy = 0;
    halt = 0; p = 0; n = stim_q.size();
    while (!halt && p < n) begin
      h = stim_q[p];
      if (h == 8'h47) begin
        exp_start = 1; halt = 1;
      end else if (h != 8'h49 && h != 8'h44) begin
        exp_err = 1; halt = 1;
      end else if (p + 2 >= n) begin
        exp_busy = 1; halt = 1;
      end else begin
        is_i = (h == 8'h49);
        c = {stim_q[p+2], stim_q[p+1]};
        if ((is_i && c > IMEM_WORDS) || (!is_i && c > DMEM_BYTES)) begin
          exp_err = 1; halt = 1;
        end else begin
          nb  = is_i ? 4 * int'(c) : int'(c);
          pay = p + 3;
          for (int k = 0; k < nb && !halt; k++) begin
            if (pay + k >= n) begin
              exp_busy = 1; halt = 1;
            end else if (!is_i) begin
              exp_d_q.push_back({5'(k), stim_q[pay+k]});
              exp_d_trig.push_back(pay + k);
            end else if (k % 4 == 3) begin
              exp_i_q.push_back({8'(k / 4), stim_q[pay+k], stim_q[pay+k-1],
                                 stim_q[pay+k-2], stim_q[pay+k-3]});
              exp_i_trig.push_back(pay + k);
            end
          end
`ifdef PROG_LOADER_CHECKSUM_EN
          if (!halt) begin
            x = 8'h00;
            for (int k = p; k < pay + nb; k++) x ^= stim_q[k];
            if (pay + nb >= n) begin
              exp_busy = 1; halt = 1;
            end else if (stim_q[pay+nb] != x) begin
              exp_err = 1; halt = 1;
            end
          end
          p = pay + nb + 1;
`else
          p = pay + nb;
`endif
        end
      end
    end
  endtask

  // Compares captured writes (value and 1-cycle latency) and final status with the model.
  task automatic check_sb(input string name);
    checks++;
    if (act_i_q.size() != exp_i_q.size()) begin
      errors++;
      $display("FAIL %s imem_write_count actual=%0d expected=%0d", name, act_i_q.size(), exp_i_q.size());
    end
    foreach (exp_i_q[i]) if (i < act_i_q.size()) begin
      checks++;
      if (act_i_q[i] !== exp_i_q[i]) begin
        errors++;
        $display("FAIL %s imem_write[%0d] actual addr=%h data=%h expected addr=%h data=%h",
                 name, i, act_i_q[i][39:32], act_i_q[i][31:0], exp_i_q[i][39:32], exp_i_q[i][31:0]);
      end
      checks++;
      if (exp_i_trig[i] >= acc_cyc_q.size() || act_i_cyc[i] != acc_cyc_q[exp_i_trig[i]] + 1) begin
        errors++;
        $display("FAIL %s imem_latency[%0d] actual_cycle=%0d expected one cycle after byte %0d",
                 name, i, act_i_cyc[i], exp_i_trig[i]);
      end
    end
    checks++;
    if (act_d_q.size() != exp_d_q.size()) begin
      errors++;
      $display("FAIL %s dmem_write_count actual=%0d expected=%0d", name, act_d_q.size(), exp_d_q.size());
    end
    foreach (exp_d_q[i]) if (i < act_d_q.size()) begin
      checks++;
      if (act_d_q[i] !== exp_d_q[i]) begin
        errors++;
        $display("FAIL %s dmem_write[%0d] actual addr=%h data=%h expected addr=%h data=%h",
                 name, i, act_d_q[i][12:8], act_d_q[i][7:0], exp_d_q[i][12:8], exp_d_q[i][7:0]);
      end
      checks++;
      if (exp_d_trig[i] >= acc_cyc_q.size() || act_d_cyc[i] != acc_cyc_q[exp_d_trig[i]] + 1) begin
        errors++;
        $display("FAIL %s dmem_latency[%0d] actual_cycle=%0d expected one cycle after byte %0d",
                 name, i, act_d_cyc[i], exp_d_trig[i]);
      end
    end
    checks++;
    if (both_we) begin
      errors++;
      $display("FAIL %s dual_strobe actual=1 expected=0", name);
    end
    checks++;
    if (bus.start_o !== exp_start) begin
      errors++;
      $display("FAIL %s start_o actual=%b expected=%b", name, bus.start_o, exp_start);
    end
    checks++;
    if (bus.err_o !== exp_err) begin
      errors++;
      $display("FAIL %s err_o actual=%b expected=%b", name, bus.err_o, exp_err);
    end
    checks++;
    if (bus.busy_o !== exp_busy) begin
      errors++;
      $display("FAIL %s busy_o actual=%b expected=%b", name, bus.busy_o, exp_busy);
    end
    checks++;
    if (bus.rx_ready_o !== !(exp_start || exp_err)) begin
      errors++;
      $display("FAIL %s rx_ready_o actual=%b expected=%b", name, bus.rx_ready_o, !(exp_start || exp_err));
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    bus.rx_valid_i = 1'b0;
    bus.rx_data_i  = 8'h00;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (bus.rx_ready_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_ready_in_reset actual=%b expected=0", bus.rx_ready_o);
    end
    checks++;
    if ({bus.imem_we_o, bus.dmem_we_o, bus.start_o, bus.busy_o, bus.err_o} !== 5'b0) begin
      errors++;
      $display("FAIL reset_flags actual=%b expected=00000",
               {bus.imem_we_o, bus.dmem_we_o, bus.start_o, bus.busy_o, bus.err_o});
    end
    checks++;
    if ({bus.imem_addr_o, bus.imem_data_o, bus.dmem_addr_o, bus.dmem_data_o} !== 53'd0) begin
      errors++;
      $display("FAIL reset_addr_data actual=%h expected=0",
               {bus.imem_addr_o, bus.imem_data_o, bus.dmem_addr_o, bus.dmem_data_o});
    end
    rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (bus.rx_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready_after actual=%b expected=1", bus.rx_ready_o);
    end
  endtask

  task automatic test_imem_basic();
    logic [7:0] pay[$];
    reset_dut();
    stim_q.delete();
    pay = {8'h13, 8'h00, 8'h00, 8'h00, 8'h20, 8'h08, 8'h00, 8'h01};
    add_frame(8'h49, 16'd2, pay);
    run_stream(1'b0);
    model_stream();
    check_sb("imem_basic");
    checks++;
    if (act_i_q.size() < 2 || act_i_q[1] !== {8'd1, 32'h01000820}) begin
      errors++;
      $display("FAIL imem_basic_word1 actual=%h expected=%h",
               (act_i_q.size() < 2) ? 40'h0 : act_i_q[1], {8'd1, 32'h01000820});
    end
    checks++;
    if (acc_cyc_q.size() != stim_q.size()) begin
      errors++;
      $display("FAIL imem_basic_accepted actual=%0d expected=%0d", acc_cyc_q.size(), stim_q.size());
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] pay[$];
    reset_dut();
    stim_q.delete();
    pay = {8'h05, 8'h0A, 8'hFF};
    add_frame(8'h44, 16'd3, pay);
    run_stream(1'b0);
    model_stream();
    check_sb("dmem_b2b");
    checks++;
    if (act_d_cyc.size() != 3 || act_d_cyc[2] - act_d_cyc[0] != 2) begin
      errors++;
      $display("FAIL dmem_b2b_spacing actual_writes=%0d expected 3 on consecutive cycles", act_d_cyc.size());
    end
    // Randomized back-to-back I frame: one word per 4 cycles.
    reset_dut();
    stim_q.delete();
    rand_pay(4 * 6, pay);
    add_frame(8'h49, 16'd6, pay);
    run_stream(1'b0);
    model_stream();
    check_sb("imem_b2b");
    checks++;
    if (act_i_cyc.size() != 6 || act_i_cyc[5] - act_i_cyc[0] != 20) begin
      errors++;
      $display("FAIL imem_b2b_spacing actual_writes=%0d expected 6 at 4-cycle spacing", act_i_cyc.size());
    end
  endtask

  task automatic test_go();
    reset_dut();
    stim_q.delete();
    stim_q = {8'h47, 8'h49, 8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44};
    run_stream(1'b0);
    model_stream();
    check_sb("go");
    checks++;
    if (acc_cyc_q.size() != 1 || start_cyc != acc_cyc_q[0] + 1) begin
      errors++;
      $display("FAIL go_start_timing actual_cycle=%0d accepted=%0d expected one cycle after G",
               start_cyc, acc_cyc_q.size());
    end
  endtask

  task automatic test_bad_count();
    logic [7:0] pay[$];
    reset_dut();
    stim_q.delete();
    stim_q = {8'h49, 8'h01, 8'h01, 8'h47};
    run_stream(1'b1);
    model_stream();
    check_sb("bad_icount");
    checks++;
    if (acc_cyc_q.size() != 3 || err_cyc != acc_cyc_q[2] + 1) begin
      errors++;
      $display("FAIL bad_icount_err_timing actual_cycle=%0d accepted=%0d expected one cycle after count_hi",
               err_cyc, acc_cyc_q.size());
    end
    reset_dut();
    stim_q.delete();
    stim_q = {8'h44, 8'h21, 8'h00, 8'h00};
    run_stream(1'b0);
    model_stream();
    check_sb("bad_dcount");
    reset_dut();
    stim_q.delete();
    stim_q = {8'h55, 8'h44, 8'h01, 8'h00, 8'h01};
    run_stream(1'b0);
    model_stream();
    check_sb("bad_header");
    // Largest legal frames.
    reset_dut();
    stim_q.delete();
    rand_pay(DMEM_BYTES, pay);
    add_frame(8'h44, 16'(DMEM_BYTES), pay);
    rand_pay(4 * IMEM_WORDS, pay);
    add_frame(8'h49, 16'(IMEM_WORDS), pay);
    run_stream(1'b0);
    model_stream();
    check_sb("max_count");
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] pay[$];
    reset_dut();
    stim_q.delete();
    stim_q = {8'h49, 8'h01, 8'h00, 8'hAA, 8'hBB};
    run_stream(1'b0);
    model_stream();
    check_sb("mid_frame_pre");
    reset_dut();
    stim_q.delete();
    pay = {8'h7E};
    add_frame(8'h44, 16'd1, pay);
    run_stream(1'b0);
    model_stream();
    check_sb("mid_frame_post");
    checks++;
    if (act_d_q.size() != 1 || act_d_q[0] !== {5'd0, 8'h7E} || act_i_q.size() != 0) begin
      errors++;
      $display("FAIL mid_frame_writes actual_dmem=%0d actual_imem=%0d expected one dmem (0,7e) only",
               act_d_q.size(), act_i_q.size());
    end
  endtask

  task automatic test_zero_count();
    logic [7:0] pay[$];
    reset_dut();
    stim_q.delete();
    pay.delete();
    add_frame(8'h44, 16'd0, pay);
    add_frame(8'h49, 16'd0, pay);
    pay = {8'h7E};
    add_frame(8'h44, 16'd1, pay);
    run_stream(1'b1);
    model_stream();
    check_sb("zero_count");
  endtask

  task automatic test_random_frames();
    logic [7:0] pay[$];
    int         c;
    bit         is_i;
    for (int r = 0; r < 3; r++) begin
      reset_dut();
      stim_q.delete();
      for (int f = 0; f < 6; f++) begin
        is_i = 1'($urandom_range(0, 1));
        c    = is_i ? $urandom_range(1, 5) : $urandom_range(1, DMEM_BYTES);
        rand_pay(is_i ? 4 * c : c, pay);
        add_frame(is_i ? 8'h49 : 8'h44, 16'(c), pay);
      end
      if (r == 1) stim_q.push_back(8'h47);
      if (r == 2) stim_q.push_back(8'h49);
      run_stream(1'b1);
      model_stream();
      check_sb("random_frames");
    end
  endtask

`ifdef PROG_LOADER_CHECKSUM_EN
  task automatic test_checksum();
    reset_dut();
    stim_q.delete();
    stim_q = {8'h44, 8'h01, 8'h00, 8'h11, 8'h54};
    run_stream(1'b0);
    model_stream();
    check_sb("csum_good");
    checks++;
    if (bus.err_o !== 1'b0 || act_d_q.size() != 1) begin
      errors++;
      $display("FAIL csum_good_fixed actual_err=%b writes=%0d expected err=0 writes=1", bus.err_o, act_d_q.size());
    end
    reset_dut();
    stim_q.delete();
    stim_q = {8'h44, 8'h01, 8'h00, 8'h11, 8'h00};
    run_stream(1'b0);
    model_stream();
    check_sb("csum_bad");
    checks++;
    if (bus.err_o !== 1'b1 || act_d_q.size() != 1) begin
      errors++;
      $display("FAIL csum_bad_fixed actual_err=%b writes=%0d expected err=1 writes=1", bus.err_o, act_d_q.size());
    end
  endtask
`endif

  // ---------------- sequence and final report ----------------
  initial begin
    test_reset();
    test_imem_basic();
    test_back_to_back();
    test_go();
    test_bad_count();
    test_reset_mid_frame();
    test_zero_count();
    test_random_frames();
`ifdef PROG_LOADER_CHECKSUM_EN
    test_checksum();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
Hardware program loader that sits in front of the CPU and is its write-side counterpart to the bench's read-side state dump. It receives a byte stream over a valid/ready handshake, writes frames into Instruction_Memory (word-wide) and Data_Memory (byte-wide), and then drives the CPU's start_i. Software-free boot path for FPGA bring-up.

Parameters:
IMEM_WORDS, 256, instruction memory depth in 32-bit words
DMEM_BYTES, 32, data memory depth in bytes
IADDR_W, 8, instruction word-address width
DADDR_W, 5, data byte-address width

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
rx_data_i  in  8  stream byte
rx_valid_i  in  1  byte valid
rx_ready_o  out  1  loader can accept byte
imem_we_o  out  1  instruction memory write strobe
imem_addr_o  out  IADDR_W  instruction word index
imem_data_o  out  32  instruction word
dmem_we_o  out  1  data memory write strobe
dmem_addr_o  out  DADDR_W  data byte address
dmem_data_o  out  8  data byte
start_o  out  1  CPU start, sticky
busy_o  out  1  frame in progress
err_o  out  1  sticky protocol error

Behaviour:
- Clock and reset: one clock, clk_i; rst_i is synchronous and active-high.
- Byte accepted on a clk_i rising edge when rx_valid_i && rx_ready_o.
- Frame: header byte, count_lo, count_hi, then payload. Count is 16-bit little-endian.
- Headers: 0x49 'I' means count is in words and payload is 4*count bytes, little-endian per word. 0x44 'D' means count is in bytes and payload is count bytes. 0x47 'G' has no count or payload and starts the CPU.
- Every I/D frame loads from address 0.
- States: IDLE, CNT_LO, CNT_HI, IPAY, DPAY, [CHK], RUN, ERR.
- IDLE: 'I' or 'D' -> CNT_LO. 'G' -> RUN. Any other byte -> ERR.
- CNT_HI transitions:
  - count==0 -> IDLE.
  - I count > IMEM_WORDS, or D count > DMEM_BYTES -> ERR.
  - otherwise -> IPAY or DPAY.
- IPAY: byte lane index 0..3 assembles the word LSB-first. On the 4th byte accepted, the next cycle has imem_we_o=1 for exactly 1 cycle, imem_addr_o=word index, imem_data_o=assembled word. Word index increments after each write. Last word -> IDLE (or CHK).
- DPAY: the cycle after each accepted byte, dmem_we_o=1 for 1 cycle with dmem_addr_o=byte index and dmem_data_o=byte. Last byte -> IDLE (or CHK).
- Write latency is exactly 1 cycle after acceptance. Back-to-back bytes must be sustainable: a 1-byte-per-cycle stream produces 1 write per cycle in D frames and 1 write per 4 cycles in I frames.
- rx_ready_o=1 in IDLE, CNT_LO, CNT_HI, IPAY, DPAY and CHK; 0 in RUN and ERR.
- RUN: start_o=1, held until reset. Further bytes are not accepted.
- ERR: err_o=1, start_o stays 0, no writes, held until reset.
- busy_o=1 in every state except IDLE, RUN and ERR.
- Write strobes are never asserted in the same cycle for imem and dmem.
- Reset values: rx_ready_o=0 during the reset cycle and 1 after; all strobes 0; addresses and data 0; start_o=0; busy_o=0; err_o=0; state IDLE.
- Reset mid-frame: partial word and counters are discarded. Memory already written is not cleared.
- A repeated frame to the same memory overwrites from address 0. Words beyond count keep their old contents.

Optional Feature:
Macro PROG_LOADER_CHECKSUM_EN.
- Defined:
  - Each I/D frame carries one trailing byte, checked in state CHK.
  - The trailing byte must equal the XOR of the header, count_lo, count_hi and all payload bytes.
  - Match -> IDLE. Mismatch -> ERR.
  - Writes already issued for that frame are not undone.
  - Count==0 frames still carry the checksum byte: CNT_HI -> CHK.
- Undefined: state CHK does not exist; no trailing byte.

Test Plan:
- Reset then stream 49 02 00 | 13 00 00 00 | 20 08 00 01 -> imem writes (0, 0x00000013), then (1, 0x01000820); imem_we_o high exactly 2 cycles; busy_o returns to 0; rx_ready_o stays 1.
- Stream 44 03 00 05 0A FF at one byte per cycle -> dmem writes (0,0x05), (1,0x0A), (2,0xFF) on 3 consecutive cycles.
- Stream 47 -> start_o=1 next cycle; rx_ready_o=0; a following 49 is ignored with no writes.
- Stream 49 01 01 (count 257 > 256) -> err_o=1 after count_hi; no writes; start_o never rises even after 47.
- Stream 49 01 00 AA BB, then rst_i=1 for 1 cycle, then 44 01 00 7E -> no imem write; dmem (0,0x7E); err_o=0.
- With PROG_LOADER_CHECKSUM_EN: 44 01 00 11 54 -> write, then IDLE. 44 01 00 11 00 -> write issued, err_o=1.
